// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload path: predecoder properties,
// controller state encoding and instruction-word register field positions.
package acc_pkg;

  typedef struct packed {
    logic       writeback;
    logic [2:0] use_rs;
  } offl_instr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    REQ
  } offl_ctrl_state_e;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS3_LSB = 27;

  function automatic logic [REG_W-1:0] rd_field(input logic [31:0] instr);
    return instr[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs_field(input logic [31:0] instr,
                                                input int unsigned idx);
    case (idx)
      0:       return instr[RS1_LSB +: REG_W];
      1:       return instr[RS2_LSB +: REG_W];
      default: return instr[RS3_LSB +: REG_W];
    endcase
  endfunction

endpackage

// File: rtl/acc_rd_scoreboard.sv
// Destination-register scoreboard: one busy bit per architectural register
// plus a saturating count of offloads still owing a writeback.
module acc_rd_scoreboard #(
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  logic [4:0]      set_rd_i,
  input  logic            clr_i,
  input  logic [4:0]      clr_rd_i,
  output logic [31:0]     busy_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        dec;

  // x0 writebacks still count as outstanding but never mark x0 busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i && (set_rd_i != '0)) set_mask[set_rd_i] = 1'b1;
    if (clr_i)                     clr_mask[clr_rd_i] = 1'b1;
  end

  assign dec    = clr_i && (count_o != '0);
  assign full_o = (count_o == CntW'(MaxOutstanding));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o  <= '0;
      count_o <= '0;
    end else begin
      busy_o <= (busy_o & ~clr_mask) | set_mask;
      if (set_i && !dec && !full_o) begin
        count_o <= count_o + 1'b1;
      end else if (dec && !set_i) begin
        count_o <= count_o - 1'b1;
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    clr_i |-> (count_o != '0));

  a_clear_busy_reg: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (clr_i && (clr_rd_i != '0)) |-> busy_o[clr_rd_i]);

endmodule

// File: rtl/acc_offload_ctrl.sv
// Offload sequencer: takes one predecoded instruction at a time, waits for
// hazard-free operands, then issues it on the accelerator request channel.
module acc_offload_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned NumRs          = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_valid_i,
  input  logic [31:0]                 instr_rdata_i,
  input  logic                        offl_accept_i,
  input  offl_instr_t                 offl_instr_i,
  input  logic [NumRs-1:0][31:0]      rs_i,
  input  logic [NumRs-1:0]            rs_valid_i,
  output logic                        instr_ready_o,
  output logic                        offl_reject_o,
  output logic                        q_valid_o,
  input  logic                        q_ready_i,
  output logic [31:0]                 q_instr_o,
  output logic [NumRs-1:0][31:0]      q_rs_o,
  input  logic                        p_valid_i,
  input  logic [4:0]                  p_rd_i,
  output logic                        p_ready_o,
  output logic [31:0]                 rd_busy_o,
  output logic                        busy_o,
  output offl_ctrl_state_e            state_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  offl_ctrl_state_e state_q;
  logic             wb_q;
  logic [NumRs-1:0] use_q;
  logic [CntW-1:0]  count;
  logic             full;
  logic             ops_ok;
  logic             issue_ok;
  logic             handshake;
  logic [4:0]       rd;

  assign rd = rd_field(q_instr_o);

  always_comb begin
    ops_ok = 1'b1;
    for (int unsigned i = 0; i < NumRs; i++) begin
      if (use_q[i] && (!rs_valid_i[i] || rd_busy_o[rs_field(q_instr_o, i)])) begin
        ops_ok = 1'b0;
      end
    end
  end

  assign issue_ok = ops_ok && (!wb_q || (!rd_busy_o[rd] && !full));

  // Request channel: a transfer happens on any edge where q_valid_o and
  // q_ready_i are both high; q_valid_o never drops and q_instr_o/q_rs_o never
  // change before that edge.
  assign handshake = (state_q == REQ) && q_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wb_q          <= 1'b0;
      use_q         <= '0;
      q_instr_o     <= '0;
      q_rs_o        <= '0;
      q_valid_o     <= 1'b0;
      instr_ready_o <= 1'b0;
      offl_reject_o <= 1'b0;
    end else begin
      instr_ready_o <= 1'b0;
      offl_reject_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            if (offl_accept_i) begin
              q_instr_o <= instr_rdata_i;
              wb_q      <= offl_instr_i.writeback;
              use_q     <= offl_instr_i.use_rs[NumRs-1:0];
              state_q   <= WAIT_OPS;
            end else begin
              offl_reject_o <= 1'b1;
            end
          end
        end
        WAIT_OPS: begin
          if (issue_ok) begin
            for (int unsigned i = 0; i < NumRs; i++) begin
              q_rs_o[i] <= use_q[i] ? rs_i[i] : 32'h0;
            end
            q_valid_o <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (q_ready_i) begin
            q_valid_o     <= 1'b0;
            instr_ready_o <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  acc_rd_scoreboard #(
    .MaxOutstanding(MaxOutstanding)
  ) u_scoreboard (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .set_i   (handshake && wb_q),
    .set_rd_i(rd),
    .clr_i   (p_valid_i),
    .clr_rd_i(p_rd_i),
    .busy_o  (rd_busy_o),
    .count_o (count),
    .full_o  (full)
  );

  assign p_ready_o = 1'b1;
  assign busy_o    = (state_q != IDLE) || (count != '0);
  assign state_o   = state_q;

endmodule

// File: tb/tb_acc_offload_ctrl.sv
// Bench for acc_offload_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_acc_offload_ctrl;
  import acc_pkg::*;

  localparam int NUM_RS  = 3;
  localparam int MAX_OUT = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   instr_valid;
  logic [31:0]            instr_rdata;
  logic                   offl_accept;
  offl_instr_t            offl_instr;
  logic [NUM_RS-1:0][31:0] rs;
  logic [NUM_RS-1:0]      rs_valid;
  logic                   instr_ready;
  logic                   offl_reject;
  logic                   q_valid;
  logic                   q_ready;
  logic [31:0]            q_instr;
  logic [NUM_RS-1:0][31:0] q_rs;
  logic                   p_valid;
  logic [4:0]             p_rd;
  logic                   p_ready;
  logic [31:0]            rd_busy;
  logic                   busy;
  offl_ctrl_state_e       state;

  acc_offload_ctrl #(.NumRs(NUM_RS), .MaxOutstanding(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_rdata_i(instr_rdata),
    .offl_accept_i(offl_accept), .offl_instr_i(offl_instr),
    .rs_i(rs), .rs_valid_i(rs_valid),
    .instr_ready_o(instr_ready), .offl_reject_o(offl_reject),
    .q_valid_o(q_valid), .q_ready_i(q_ready),
    .q_instr_o(q_instr), .q_rs_o(q_rs),
    .p_valid_i(p_valid), .p_rd_i(p_rd), .p_ready_o(p_ready),
    .rd_busy_o(rd_busy), .busy_o(busy), .state_o(state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: instruction in hand + list of rds still owed a writeback
  bit          m_have, m_issued, m_ready, m_reject, m_wb;
  bit [2:0]    m_use;
  logic [31:0] m_instr;
  logic [31:0] m_rs [NUM_RS];
  int          m_out[$];

  function automatic int fld(input logic [31:0] w, input int lsb);
    logic [31:0] s;
    s = w >> lsb;
    return int'(s[4:0]);
  endfunction

  function automatic int src_lsb(input int i);
    return (i == 0) ? 15 : (i == 1) ? 20 : 27;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] v;
    v = '0;
    foreach (m_out[k]) if (m_out[k] != 0) v[m_out[k]] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] bv;
    bit          ok, hs, iss;
    if (!rst_n) begin
      m_have = 0; m_issued = 0; m_ready = 0; m_reject = 0; m_wb = 0; m_use = 0;
      m_instr = '0;
      for (int i = 0; i < NUM_RS; i++) m_rs[i] = '0;
      m_out.delete();
    end else begin
      bv = m_busy();
      ok = 1;
      for (int i = 0; i < NUM_RS; i++)
        if (m_use[i] && (!rs_valid[i] || bv[fld(m_instr, src_lsb(i))])) ok = 0;
      if (m_wb && (bv[fld(m_instr, 7)] || m_out.size() >= MAX_OUT)) ok = 0;
      hs  = m_issued && q_ready;
      iss = m_have && !m_issued && ok;
      m_ready  = 0;
      m_reject = 0;
      if (p_valid) begin
        for (int k = 0; k < m_out.size(); k++)
          if (m_out[k] == int'(p_rd)) begin m_out.delete(k); break; end
      end
      if (hs) begin
        if (m_wb) m_out.push_back(fld(m_instr, 7));
        m_have = 0; m_issued = 0; m_ready = 1;
      end else if (iss) begin
        m_issued = 1;
        for (int i = 0; i < NUM_RS; i++) m_rs[i] = m_use[i] ? rs[i] : 32'h0;
      end else if (!m_have && instr_valid) begin
        if (offl_accept) begin
          m_have = 1; m_instr = instr_rdata;
          m_wb = offl_instr.writeback; m_use = offl_instr.use_rs;
        end else begin
          m_reject = 1;
        end
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin : compare
    offl_ctrl_state_e es;
    es = !m_have ? IDLE : (m_issued ? REQ : WAIT_OPS);
    check("q_valid", 32'(q_valid), 32'(m_issued));
    check("instr_ready", 32'(instr_ready), 32'(m_ready));
    check("offl_reject", 32'(offl_reject), 32'(m_reject));
    check("rd_busy", rd_busy, m_busy());
    check("busy", 32'(busy), 32'(m_have || (m_out.size() != 0)));
    check("p_ready", 32'(p_ready), 32'd1);
    check("state", 32'(state), 32'(es));
    if (m_issued) begin
      check("q_instr", q_instr, m_instr);
      for (int i = 0; i < NUM_RS; i++) check("q_rs", q_rs[i], m_rs[i]);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input int rs3);
    logic [31:0] w;
    w = $urandom;
    w[11:7]  = rd[4:0];
    w[19:15] = rs1[4:0];
    w[24:20] = rs2[4:0];
    w[31:27] = rs3[4:0];
    return w;
  endfunction

  task automatic send(input logic [31:0] w, input bit wb, input bit [2:0] use_rs);
    instr_rdata = w;
    offl_instr.writeback = wb;
    offl_instr.use_rs = use_rs;
    instr_valid = 1'b1;
    offl_accept = 1'b1;
    tick();
    instr_valid = 1'b0;
    offl_accept = 1'b0;
  endtask

  task automatic run_one(input string name, input int rd, input bit wb);
    send(mk(rd, 0, 0, 0), wb, 3'b000);
    for (int k = 0; k < 50 && !instr_ready; k++) tick();
    check(name, 32'(instr_ready), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_out.size() > 0; k++) begin
      p_valid = 1'b1;
      p_rd = 5'(m_out[0]);
      tick();
      p_valid = 1'b0;
    end
    tick();
    check("drain busy", 32'(busy), 32'd0);
  endtask

  initial begin : timeout
    #2_000_000;
    n_err++;
    $display("FAIL timeout: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : stimulus
    logic [31:0] w;
    logic [31:0] r0, r1, r2;
    instr_valid = 0; instr_rdata = '0; offl_accept = 0; offl_instr = '0;
    rs = '0; rs_valid = '1; q_ready = 1; p_valid = 0; p_rd = '0;
    @(negedge clk); @(negedge clk);
    check("reset q_valid", 32'(q_valid), 32'd0);
    check("reset rd_busy", rd_busy, 32'd0);
    check("reset q_instr", q_instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // single offload: rd=x5, rs1/rs2 used
    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    rs = {r2, r1, r0};
    send(mk(5, 1, 2, 3), 1'b1, 3'b011);
    check("t1 accept q_valid", 32'(q_valid), 32'd0);
    check("t1 accept state", 32'(state), 32'(WAIT_OPS));
    tick();
    check("t1 q_valid at +2", 32'(q_valid), 32'd1);
    check("t1 q_rs0", q_rs[0], r0);
    check("t1 q_rs2 unused", q_rs[2], 32'd0);
    tick();
    check("t1 instr_ready", 32'(instr_ready), 32'd1);
    check("t1 rd_busy", rd_busy, 32'h0000_0020);
    p_valid = 1'b1; p_rd = 5'd5;
    tick();
    p_valid = 1'b0;
    check("t1 resp rd_busy", rd_busy, 32'd0);
    check("t1 resp busy", 32'(busy), 32'd0);
    check("t1 single pulse", 32'(instr_ready), 32'd0);

    // RAW hazard on x7
    run_one("t2 producer", 7, 1'b1);
    check("t2 rd_busy", rd_busy, 32'h0000_0080);
    send(mk(9, 7, 0, 0), 1'b0, 3'b001);
    for (int k = 0; k < 4; k++) begin
      rs[0] = $urandom;
      tick();
      check("t2 held", 32'(state), 32'(WAIT_OPS));
    end
    p_valid = 1'b1; p_rd = 5'd7; rs[0] = 32'hCAFE_0007;
    tick();
    p_valid = 1'b0;
    check("t2 not yet", 32'(q_valid), 32'd0);
    tick();
    check("t2 issue", 32'(q_valid), 32'd1);
    check("t2 operand", q_rs[0], 32'hCAFE_0007);
    tick();
    check("t2 done", 32'(instr_ready), 32'd1);

    // backpressure
    q_ready = 1'b0;
    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    rs = {r2, r1, r0};
    w = mk(3, 4, 5, 6);
    send(w, 1'b0, 3'b111);
    for (int k = 0; k < 10 && !q_valid; k++) tick();
    check("t3 q_valid", 32'(q_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      rs = {32'($urandom), 32'($urandom), 32'($urandom)};
      tick();
      check("t3 hold valid", 32'(q_valid), 32'd1);
      check("t3 hold instr", q_instr, w);
      check("t3 hold rs1", q_rs[1], r1);
      check("t3 no ready", 32'(instr_ready), 32'd0);
    end
    q_ready = 1'b1;
    tick();
    check("t3 ready", 32'(instr_ready), 32'd1);
    tick();
    check("t3 ready once", 32'(instr_ready), 32'd0);

    // outstanding limit and concurrent issue/response
    for (int r = 1; r <= 4; r++) run_one("t4 fill", r, 1'b1);
    check("t4 full busy", rd_busy, 32'h0000_001E);
    send(mk(6, 0, 0, 0), 1'b1, 3'b000);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4 fifth held", 32'(state), 32'(WAIT_OPS));
    end
    q_ready = 1'b0;
    p_valid = 1'b1; p_rd = 5'd1;
    tick();
    p_valid = 1'b0;
    check("t4 after x1", rd_busy, 32'h0000_001C);
    tick();
    check("t4 fifth issues", 32'(q_valid), 32'd1);
    q_ready = 1'b1; p_valid = 1'b1; p_rd = 5'd2;
    tick();
    p_valid = 1'b0;
    check("t4 hs+resp", rd_busy, 32'h0000_0058);
    run_one("t4 x8", 8, 1'b1);
    send(mk(9, 0, 0, 0), 1'b1, 3'b000);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4 count held", 32'(state), 32'(WAIT_OPS));
    end
    p_valid = 1'b1; p_rd = 5'd3;
    tick();
    p_valid = 1'b0;
    for (int k = 0; k < 10 && !instr_ready; k++) tick();
    check("t4 x9 done", 32'(instr_ready), 32'd1);
    drain();

    // reject and x0 writeback
    instr_rdata = $urandom; instr_valid = 1'b1; offl_accept = 1'b0;
    tick();
    instr_valid = 1'b0;
    check("t5 reject", 32'(offl_reject), 32'd1);
    check("t5 idle", 32'(state), 32'(IDLE));
    tick();
    check("t5 reject once", 32'(offl_reject), 32'd0);
    run_one("t5 x0", 0, 1'b1);
    tick();
    check("t5 x0 rd_busy", rd_busy, 32'd0);
    check("t5 x0 counted", 32'(busy), 32'd1);
    drain();

    // reset while a request is pending
    run_one("t6 x11", 11, 1'b1);
    q_ready = 1'b0;
    send(mk(10, 0, 0, 0), 1'b1, 3'b000);
    for (int k = 0; k < 10 && !q_valid; k++) tick();
    check("t6 in REQ", 32'(q_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async q_valid", 32'(q_valid), 32'd0);
    check("t6 async rd_busy", rd_busy, 32'd0);
    check("t6 async busy", 32'(busy), 32'd0);
    check("t6 async q_instr", q_instr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    q_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6 no ready", 32'(instr_ready), 32'd0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      offl_accept = ($urandom_range(0, 4) != 0);
      instr_rdata = mk($urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7));
      offl_instr.writeback = 1'($urandom_range(0, 1));
      offl_instr.use_rs = 3'($urandom_range(0, 7));
      for (int i = 0; i < NUM_RS; i++) begin
        rs[i] = $urandom;
        rs_valid[i] = ($urandom_range(0, 5) != 0);
      end
      q_ready = ($urandom_range(0, 2) != 0);
      if (m_out.size() > 0 && $urandom_range(0, 2) == 0) begin
        p_valid = 1'b1;
        p_rd = 5'(m_out[$urandom_range(0, m_out.size() - 1)]);
      end else begin
        p_valid = 1'b0;
        p_rd = 5'($urandom_range(0, 31));
      end
      tick();
    end
    instr_valid = 1'b0;
    p_valid = 1'b0;
    rs_valid = '1;
    q_ready = 1'b1;
    for (int k = 0; k < 20 && m_have; k++) tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
